// File: rtl/btn_pkg.sv
// btn_pkg: channel state encoding, default sizes and button index constants
package btn_pkg;
   typedef enum logic [1:0] {STABLE_LOW, RISE_WAIT, STABLE_HIGH, FALL_WAIT} ch_state_t;
   localparam int N_BTN_DEF = 5;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int BTN_C = 0;
   localparam int BTN_R = 1;
   localparam int BTN_L = 2;
   localparam int BTN_D = 3;
   localparam int BTN_U = 4;
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button (clk, reset_n, raw -> level, press, rls) with 2-flop sync, debounce FSM and edge pulses
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rls
);
   ch_state_t state;
   logic [1:0] sync;
   logic [CNT_W-1:0] cnt;
   logic s, hi, done;
   assign s = sync[1];
   assign hi = state == STABLE_HIGH || state == FALL_WAIT;
   assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync <= '0;
         cnt <= '0;
         state <= STABLE_LOW;
         level <= 1'b0;
         press <= 1'b0;
         rls <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         level <= hi;
         press <= hi & ~level;
         rls <= ~hi & level;
         case (state)
            STABLE_LOW:
               if (s) begin
                  state <= RISE_WAIT;
                  cnt <= CNT_W'(1);
               end
            RISE_WAIT:
               if (!s) begin
                  state <= STABLE_LOW;
                  cnt <= '0;
               end else if (done) begin
                  state <= STABLE_HIGH;
                  cnt <= '0;
               end else cnt <= cnt + CNT_W'(1);
            STABLE_HIGH:
               if (!s) begin
                  state <= FALL_WAIT;
                  cnt <= CNT_W'(1);
               end
            default:
               if (s) begin
                  state <= STABLE_HIGH;
                  cnt <= '0;
               end else if (done) begin
                  state <= STABLE_LOW;
                  cnt <= '0;
               end else cnt <= cnt + CNT_W'(1);
         endcase
      end
endmodule

// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: debounced button levels, press/release pulses, W1C sticky press flags and event_any; PRESS_TIMESTAMP_EN adds press_ts/press_idx
module btn_input_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN = N_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef PRESS_TIMESTAMP_EN
   , parameter int TS_W = 32
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] event_clear,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] event_sticky,
   output logic             event_any
`ifdef PRESS_TIMESTAMP_EN
   , output logic [TS_W-1:0] press_ts
   , output logic [2:0]      press_idx
`endif
);
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch (
         .clk(clk),
         .reset_n(reset_n),
         .raw(btn_raw[i]),
         .level(btn_level[i]),
         .press(btn_press[i]),
         .rls(btn_release[i])
      );
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) event_sticky <= '0;
      else event_sticky <= (event_sticky & ~event_clear) | btn_press;
   assign event_any = |event_sticky;
`ifdef PRESS_TIMESTAMP_EN
   logic [TS_W-1:0] ts;
   logic [2:0] low_idx;
   always_comb begin
      low_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) low_idx = btn_press[i] ? 3'(i) : low_idx;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ts <= '0;
         press_ts <= '0;
         press_idx <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (|btn_press) begin
            press_ts <= ts;
            press_idx <= low_idx;
         end
      end
`endif
endmodule
